bird_sprite_renderer: RTL and testbench
=======================================

# bird_sprite_renderer

Consumes the bird motion outputs (`birdY`, `bird_state`, `bird_angle`) and turns them into pixels on the VGA scan path.
- Latches the bird position and pose once per frame.
- Pipelines sprite-sheet ROM lookups against the pixel scan coordinates and composites the bird over the background colour.
- Produces a per-frame collision flag from bird/pipe pixel overlap and ground contact.

Sits between the bird physics block, the sprite ROM and the VGA output mux.

## Interface
- `BIRD_SIZE_X`, default 34: sprite width in pixels.
- `BIRD_SIZE_Y`, default 24: sprite height in pixels.
- `BIRD_X`, default 100: fixed left column of the bird.
- `GROUND_Y`, default 400: first row of the ground.
- `COLOR_W`, default 16: colour width.
- `ADDR_W`, default 13: sprite ROM address width.
- `KEY_COLOR`, default 16'hF81F: transparent colour in the ROM.
- `clk` in 1: pixel clock.
- `rst` in 1: reset, asynchronous, active-high.
- `frame_start` in 1: one-cycle pulse at the start of vertical blanking.
- `pix_valid` in 1: `pix_x`/`pix_y` address a visible pixel.
- `pix_x` in 10: scan column.
- `pix_y` in 10: scan row.
- `bg_color` in COLOR_W: background/pipe colour for this pixel.
- `pipe_px` in 1: this pixel belongs to a pipe.
- `birdY` in 32: bird top row, from physics.
- `bird_state` in 2: flap frame (0..2).
- `bird_angle` in 2: angle frame (0..2).
- `rom_addr` out ADDR_W: sprite ROM address; ROM is synchronous, data valid one cycle later.
- `rom_data` in COLOR_W: sprite ROM read data.
- `pix_out` out COLOR_W: composited colour.
- `pix_out_valid` out 1: `pix_valid` delayed by the pipeline.
- `bird_px` out 1: `pix_out` came from an opaque bird pixel.
- `collision` out 1: overlap or ground contact detected in the previous frame; held for one frame.

## Operation
**Shadow registers**
- On `frame_start`, `by`/`bs`/`ba` <= `birdY`/`bird_state`/`bird_angle`.
- Pixels presented in the same cycle as `frame_start` still use the old shadow values.
- Reset values: `by` = (480−BIRD_SIZE_Y)/2, `bs` = 0, `ba` = 0.

**Pose clamping**
- `bs` or `ba` equal to 3 is treated as 0.
- Frame index f = `ba`*3 + `bs`, range 0..8.

**Hit test (stage 1)**
- hit = `pix_valid` && `pix_x` ≥ BIRD_X && `pix_x` < BIRD_X+BIRD_SIZE_X && `pix_y` ≥ `by` && `pix_y` < `by`+BIRD_SIZE_Y.
- Compare in 32-bit unsigned; `pix_x`/`pix_y` are zero-extended.
- If `by` ≥ 480, nothing is drawn.

**ROM address**
- `rom_addr` = f*BIRD_SIZE_X*BIRD_SIZE_Y + (`pix_y`−`by`)*BIRD_SIZE_X + (`pix_x`−BIRD_X), truncated to ADDR_W.
- When not hit, `rom_addr` holds its previous value.

**Composite (stage 3)**
- opaque = hit_d2 && `rom_data` ≠ KEY_COLOR.
- `pix_out` = opaque ? `rom_data` : bg_d2.
- `bird_px` = opaque.
- When `pix_out_valid` = 0, `pix_out` = 0 and `bird_px` = 0.

**Collision**
- A sticky flag `coll_acc` sets when `bird_px` && pipe_d3 at stage 3.
- It also sets when a hit pixel has `pix_y` ≥ GROUND_Y.
- On `frame_start`: `collision` <= `coll_acc` OR this cycle's stage-3 event, and `coll_acc` <= 0.
- An event at stage 3 in the `frame_start` cycle counts toward the ending frame.

**Reset**
- All outputs reset to 0, and `rom_addr` resets to 0.
- Pipeline valids, `coll_acc` and `collision` clear.
- An asserted `rst` mid-frame discards in-flight pixels immediately; no stale `pix_out_valid` follows.

## Timing
- Inputs sampled at edge n.
- `rom_addr`, hit_d1, bg_d1 and pipe_d1 are registered at edge n+1.
- ROM data is valid after edge n+2, with hit_d2, bg_d2 and pipe_d2.
- `pix_out`, `pix_out_valid` and `bird_px` are registered at edge n+3. Fixed latency is 3 cycles.
- Full throughput: one pixel per cycle, no stalls, no backpressure.
- `collision` changes only at the edge after `frame_start` and is stable for the whole following frame.
- A new shadow pose applies to the first pixel presented after the `frame_start` cycle.

## Test plan
- **Reset:** assert `rst` mid-scan → all outputs 0 next cycle. Release, pulse `frame_start` with `birdY`=50 → scanning (100,50) gives `rom_addr`=0 one cycle later and `bird_px`=1 three cycles after input (ROM model non-key).
- **Pose and address:** `bird_state`=2, `bird_angle`=1 latched; pixel (101,51) → `rom_addr` = 5*816 + 34 + 1 = 4115. `bird_state`=3 behaves as 0.
- **Transparency and bounds:** ROM returns KEY_COLOR → `pix_out`=`bg_color`, `bird_px`=0. Pixel (134,50) and (100,74) → not hit, `bg_color` passes, `rom_addr` unchanged.
- **Shadow latch:** change `birdY` from 50 to 60 mid-frame without `frame_start` → rendering stays at row 50. After `frame_start`, rows 60..83 are drawn. Pixel in the same cycle as `frame_start` uses row 50.
- **Collision:** opaque bird pixel with `pipe_px`=1 at frame k → `collision`=1 for all of frame k+1, 0 in frame k+2 if there is no event. Latched `birdY`=390 → ground collision. Event at stage 3 coinciding with `frame_start` → reported immediately.

Source files
------------

// File: rtl/bird_sprite_renderer.sv
// Bird sprite renderer: latches the bird pose once per frame, looks the sprite up
// in a 3-stage pipeline, composites it over the background and flags collisions.
module bird_sprite_renderer #(
    parameter int                 BIRD_SIZE_X = 34,
    parameter int                 BIRD_SIZE_Y = 24,
    parameter int                 BIRD_X      = 100,
    parameter int                 GROUND_Y    = 400,
    parameter int                 COLOR_W     = 16,
    parameter int                 ADDR_W      = 13,
    parameter logic [COLOR_W-1:0] KEY_COLOR   = 16'hF81F
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               pix_valid,
    input  logic [9:0]         pix_x,
    input  logic [9:0]         pix_y,
    input  logic [COLOR_W-1:0] bg_color,
    input  logic               pipe_px,
    input  logic [31:0]        birdY,
    input  logic [1:0]         bird_state,
    input  logic [1:0]         bird_angle,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic [COLOR_W-1:0] pix_out,
    output logic               pix_out_valid,
    output logic               bird_px,
    output logic               collision
);
    localparam logic [31:0] X_LO     = 32'(BIRD_X);
    localparam logic [31:0] X_HI     = 32'(BIRD_X + BIRD_SIZE_X);
    localparam logic [31:0] SZ_X     = 32'(BIRD_SIZE_X);
    localparam logic [31:0] SZ_Y     = 32'(BIRD_SIZE_Y);
    localparam logic [31:0] FRAME_SZ = 32'(BIRD_SIZE_X * BIRD_SIZE_Y);
    localparam logic [31:0] GND_Y    = 32'(GROUND_Y);
    localparam logic [31:0] VIS_H    = 32'd480;
    localparam logic [31:0] BY_RST   = 32'((480 - BIRD_SIZE_Y) / 2);

    // Pose code 3 is not a valid frame and folds back to 0.
    function automatic logic [31:0] pose_frame(input logic [1:0] s, input logic [1:0] a);
        logic [31:0] sc;
        logic [31:0] ac;
        sc = (s == 2'd3) ? 32'd0 : {30'd0, s};
        ac = (a == 2'd3) ? 32'd0 : {30'd0, a};
        return ac * 32'd3 + sc;
    endfunction

    logic [31:0] by;
    logic [1:0]  bs;
    logic [1:0]  ba;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            by <= BY_RST;
            bs <= '0;
            ba <= '0;
        end else if (frame_start) begin
            by <= birdY;
            bs <= bird_state;
            ba <= bird_angle;
        end
    end

    // Stage 0: hit test and sprite address from the scan coordinates
    logic [31:0]       px_x;
    logic [31:0]       px_y;
    logic              hit_p0;
    logic              gnd_p0;
    logic [ADDR_W-1:0] addr_p0;

    assign px_x    = {22'd0, pix_x};
    assign px_y    = {22'd0, pix_y};
    assign hit_p0  = pix_valid && (px_x >= X_LO) && (px_x < X_HI) && (by < VIS_H)
                     && (px_y >= by) && (px_y < by + SZ_Y);
    assign gnd_p0  = hit_p0 && (px_y >= GND_Y);
    assign addr_p0 = ADDR_W'(pose_frame(bs, ba) * FRAME_SZ + (px_y - by) * SZ_X + (px_x - X_LO));

    // Stage 1: ROM address issued, pixel attributes follow
    logic               vld_p1;
    logic               hit_p1;
    logic               gnd_p1;
    logic               pipe_p1;
    logic [COLOR_W-1:0] bg_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            hit_p1   <= 1'b0;
            gnd_p1   <= 1'b0;
            pipe_p1  <= 1'b0;
            rom_addr <= '0;
        end else begin
            vld_p1  <= pix_valid;
            hit_p1  <= hit_p0;
            gnd_p1  <= gnd_p0;
            pipe_p1 <= pipe_px;
            if (hit_p0)
                rom_addr <= addr_p0;
        end
    end

    // Stage 2: ROM data arrives alongside these registers
    logic               vld_p2;
    logic               hit_p2;
    logic               gnd_p2;
    logic               pipe_p2;
    logic [COLOR_W-1:0] bg_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            hit_p2  <= 1'b0;
            gnd_p2  <= 1'b0;
            pipe_p2 <= 1'b0;
        end else begin
            vld_p2  <= vld_p1;
            hit_p2  <= hit_p1;
            gnd_p2  <= gnd_p1;
            pipe_p2 <= pipe_p1;
        end
    end

    always_ff @(posedge clk) begin
        bg_p1 <= bg_color;
        bg_p2 <= bg_p1;
    end

    // Stage 3: composite and collision event
    logic opaque_p2;
    logic pipe_p3;
    logic gnd_p3;
    logic ev_p3;
    logic coll_acc;

    assign opaque_p2 = hit_p2 && (rom_data != KEY_COLOR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_out       <= '0;
            pix_out_valid <= 1'b0;
            bird_px       <= 1'b0;
            pipe_p3       <= 1'b0;
            gnd_p3        <= 1'b0;
        end else begin
            pix_out_valid <= vld_p2;
            pix_out       <= vld_p2 ? (opaque_p2 ? rom_data : bg_p2) : '0;
            bird_px       <= vld_p2 && opaque_p2;
            pipe_p3       <= pipe_p2;
            gnd_p3        <= gnd_p2;
        end
    end

    assign ev_p3 = (bird_px && pipe_p3) || gnd_p3;

    // An event visible in the frame_start cycle still belongs to the ending frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coll_acc  <= 1'b0;
            collision <= 1'b0;
        end else if (frame_start) begin
            collision <= coll_acc || ev_p3;
            coll_acc  <= 1'b0;
        end else if (ev_p3) begin
            coll_acc  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bird_sprite_renderer.sv
// Bench for bird_sprite_renderer: synchronous ROM model, scoreboard of expected
// pixels/addresses, vector table plus hand-written shadow, pose and collision sequences.
module tb_bird_sprite_renderer;
    localparam logic [15:0] KEY = 16'hF81F;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [15:0] bg_color;
    logic        pipe_px;
    logic [31:0] birdY;
    logic [1:0]  bird_state;
    logic [1:0]  bird_angle;
    logic [12:0] rom_addr;
    logic [15:0] rom_q;
    logic [15:0] pix_out;
    logic        pix_out_valid;
    logic        bird_px;
    logic        collision;

    bird_sprite_renderer dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .bg_color(bg_color), .pipe_px(pipe_px),
        .birdY(birdY), .bird_state(bird_state), .bird_angle(bird_angle),
        .rom_addr(rom_addr), .rom_data(rom_q), .pix_out(pix_out),
        .pix_out_valid(pix_out_valid), .bird_px(bird_px), .collision(collision)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic key_mode = 1'b0;
    function automatic logic [15:0] rom_fn(input logic [12:0] a);
        return {3'b000, a} ^ 16'h0A5A;
    endfunction
    always @(posedge clk) rom_q <= key_mode ? KEY : rom_fn(rom_addr);

    typedef struct { int unsigned due; logic v; logic [15:0] pix; logic bpx; } pix_exp_t;
    typedef struct { int unsigned due; logic [12:0] addr; } addr_exp_t;
    typedef struct { logic [9:0] x; logic [9:0] y; logic [15:0] bg; logic hit; logic [12:0] addr; } vec_t;

    pix_exp_t  pq[$];
    addr_exp_t aq[$];
    int checks   = 0;
    int failures = 0;

    logic [31:0] mby;
    logic [1:0]  mbs;
    logic [1:0]  mba;
    logic [12:0] m_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        while (aq.size() > 0 && aq[0].due <= cyc) begin
            addr_exp_t ea;
            ea = aq.pop_front();
            chk("rom_addr", {19'd0, rom_addr}, {19'd0, ea.addr});
        end
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            pix_exp_t ep;
            ep = pq.pop_front();
            chk("pix_out_valid", {31'd0, pix_out_valid}, {31'd0, ep.v});
            chk("pix_out", {16'd0, pix_out}, {16'd0, ep.pix});
            chk("bird_px", {31'd0, bird_px}, {31'd0, ep.bpx});
        end
    end

    task automatic model_reset();
        mby    = 32'd228;
        mbs    = 2'd0;
        mba    = 2'd0;
        m_addr = 13'd0;
    endtask

    task automatic model(input logic v, input logic [9:0] x, input logic [9:0] y,
                         output logic hit, output logic [12:0] a);
        logic [31:0] s, an, f, xx, yy;
        s  = (mbs == 2'd3) ? 32'd0 : {30'd0, mbs};
        an = (mba == 2'd3) ? 32'd0 : {30'd0, mba};
        f  = an * 32'd3 + s;
        xx = {22'd0, x};
        yy = {22'd0, y};
        hit = v && (xx >= 32'd100) && (xx < 32'd134) && (mby < 32'd480)
              && (yy >= mby) && (yy < mby + 32'd24);
        a = 13'(f * 32'd816 + (yy - mby) * 32'd34 + (xx - 32'd100));
    endtask

    task automatic drive_exp(input logic v, input logic [9:0] x, input logic [9:0] y,
                             input logic [15:0] bg, input logic pp, input logic fs,
                             input logic hit, input logic [12:0] a);
        addr_exp_t ea;
        pix_exp_t  ep;
        logic [15:0] d;
        logic op;
        @(posedge clk);
        #1;
        pix_valid = v; pix_x = x; pix_y = y; bg_color = bg; pipe_px = pp; frame_start = fs;
        if (hit) m_addr = a;
        ea.due = cyc + 1; ea.addr = m_addr;
        aq.push_back(ea);
        d  = key_mode ? KEY : rom_fn(m_addr);
        op = hit && (d != KEY);
        ep.due = cyc + 3; ep.v = v; ep.pix = v ? (op ? d : bg) : 16'h0; ep.bpx = op;
        pq.push_back(ep);
        if (fs) begin
            mby = birdY; mbs = bird_state; mba = bird_angle;
        end
    endtask

    task automatic px(input logic v, input logic [9:0] x, input logic [9:0] y,
                      input logic [15:0] bg, input logic pp, input logic fs);
        logic h;
        logic [12:0] a;
        model(v, x, y, h, a);
        drive_exp(v, x, y, bg, pp, fs, h, a);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) px(1'b0, 10'd0, 10'd0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic fstart();
        px(1'b0, 10'd0, 10'd0, 16'h0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_x = '0; pix_y = '0;
        bg_color = '0; pipe_px = 1'b0; birdY = '0; bird_state = '0; bird_angle = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pix_out", {16'd0, pix_out}, 32'd0);
        chk("rst_valid", {31'd0, pix_out_valid}, 32'd0);
        chk("rst_bird_px", {31'd0, bird_px}, 32'd0);
        chk("rst_collision", {31'd0, collision}, 32'd0);
        chk("rst_rom_addr", {19'd0, rom_addr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // First render after reset: birdY=50, pixel (100,50) -> address 0, opaque
        birdY = 32'd50;
        fstart();
        drive_exp(1'b1, 10'd100, 10'd50, 16'h1234, 1'b0, 1'b0, 1'b1, 13'd0);
        idle(2);

        tbl[0] = '{10'd100, 10'd50, 16'h1100, 1'b1, 13'd0};
        tbl[1] = '{10'd133, 10'd50, 16'h1101, 1'b1, 13'd33};
        tbl[2] = '{10'd134, 10'd50, 16'h1102, 1'b0, 13'd0};
        tbl[3] = '{10'd100, 10'd73, 16'h1103, 1'b1, 13'd782};
        tbl[4] = '{10'd100, 10'd74, 16'h1104, 1'b0, 13'd0};
        tbl[5] = '{10'd99,  10'd60, 16'h1105, 1'b0, 13'd0};
        tbl[6] = '{10'd101, 10'd51, 16'h1106, 1'b1, 13'd35};
        tbl[7] = '{10'd120, 10'd60, 16'h1107, 1'b1, 13'd360};
        tbl[8] = '{10'd133, 10'd73, 16'h1108, 1'b1, 13'd815};
        for (int i = 0; i < 9; i++)
            drive_exp(1'b1, tbl[i].x, tbl[i].y, tbl[i].bg, 1'b0, 1'b0, tbl[i].hit, tbl[i].addr);
        idle(3);

        // Pose selection, including code 3 folding to 0
        bird_state = 2'd2; bird_angle = 2'd1; fstart();
        drive_exp(1'b1, 10'd101, 10'd51, 16'h2200, 1'b0, 1'b0, 1'b1, 13'd4115);
        bird_state = 2'd3; bird_angle = 2'd1; fstart();
        drive_exp(1'b1, 10'd101, 10'd51, 16'h2201, 1'b0, 1'b0, 1'b1, 13'd2483);
        bird_state = 2'd2; bird_angle = 2'd3; fstart();
        drive_exp(1'b1, 10'd101, 10'd51, 16'h2202, 1'b0, 1'b0, 1'b1, 13'd1667);
        bird_state = 2'd0; bird_angle = 2'd0; fstart();
        idle(3);

        // Transparent ROM pixel lets the background through
        key_mode = 1'b1;
        px(1'b1, 10'd100, 10'd50, 16'hABCD, 1'b0, 1'b0);
        px(1'b1, 10'd110, 10'd52, 16'hABCE, 1'b0, 1'b0);
        idle(3);
        key_mode = 1'b0;

        // Shadow latch: birdY change only takes effect after frame_start
        birdY = 32'd60;
        drive_exp(1'b1, 10'd100, 10'd50, 16'h3300, 1'b0, 1'b0, 1'b1, 13'd0);
        drive_exp(1'b1, 10'd100, 10'd80, 16'h3301, 1'b0, 1'b0, 1'b0, 13'd0);
        drive_exp(1'b1, 10'd100, 10'd51, 16'h3302, 1'b0, 1'b1, 1'b1, 13'd34);
        drive_exp(1'b1, 10'd100, 10'd60, 16'h3303, 1'b0, 1'b0, 1'b1, 13'd0);
        drive_exp(1'b1, 10'd100, 10'd83, 16'h3304, 1'b0, 1'b0, 1'b1, 13'd782);
        drive_exp(1'b1, 10'd100, 10'd84, 16'h3305, 1'b0, 1'b0, 1'b0, 13'd0);
        drive_exp(1'b1, 10'd100, 10'd59, 16'h3306, 1'b0, 1'b0, 1'b0, 13'd0);
        idle(3);

        // Off-screen bird draws nothing; row 479 still draws and touches ground
        birdY = 32'd500; fstart();
        drive_exp(1'b1, 10'd100, 10'd500, 16'h4400, 1'b0, 1'b0, 1'b0, 13'd0);
        birdY = 32'd479; fstart();
        drive_exp(1'b1, 10'd100, 10'd479, 16'h4401, 1'b0, 1'b0, 1'b1, 13'd0);
        idle(4);
        birdY = 32'd50; fstart();
        idle(1);
        chk("coll_ground_479", {31'd0, collision}, 32'd1);
        fstart();
        idle(1);
        chk("coll_clear_after_479", {31'd0, collision}, 32'd0);

        // Pipe overlap in frame k -> flag for frame k+1 only
        px(1'b1, 10'd110, 10'd55, 16'h5500, 1'b1, 1'b0);
        px(1'b1, 10'd200, 10'd55, 16'h5501, 1'b1, 1'b0);
        idle(4);
        chk("coll_before_frame_end", {31'd0, collision}, 32'd0);
        fstart();
        idle(1);
        chk("coll_pipe_frame_k1", {31'd0, collision}, 32'd1);
        px(1'b1, 10'd110, 10'd55, 16'h5502, 1'b0, 1'b0);
        px(1'b1, 10'd200, 10'd60, 16'h5503, 1'b1, 1'b0);
        idle(8);
        chk("coll_pipe_frame_k1_mid", {31'd0, collision}, 32'd1);
        fstart();
        idle(1);
        chk("coll_frame_k2", {31'd0, collision}, 32'd0);

        // Ground contact with birdY=390
        birdY = 32'd390; fstart();
        px(1'b1, 10'd100, 10'd400, 16'h6600, 1'b0, 1'b0);
        idle(4);
        birdY = 32'd50; fstart();
        idle(1);
        chk("coll_ground_390", {31'd0, collision}, 32'd1);
        idle(3);
        fstart();
        idle(1);
        chk("coll_ground_cleared", {31'd0, collision}, 32'd0);

        // Stage-3 event in the frame_start cycle is reported at that boundary
        px(1'b1, 10'd110, 10'd55, 16'h7700, 1'b1, 1'b0);
        idle(2);
        fstart();
        idle(1);
        chk("coll_same_cycle", {31'd0, collision}, 32'd1);
        idle(5);
        fstart();
        idle(1);
        chk("coll_same_cycle_not_carried", {31'd0, collision}, 32'd0);

        // Mid-scan reset discards in-flight pixels and the collision flag
        px(1'b1, 10'd110, 10'd55, 16'h8800, 1'b1, 1'b0);
        idle(4);
        fstart();
        px(1'b1, 10'd110, 10'd56, 16'h8801, 1'b0, 1'b0);
        px(1'b1, 10'd111, 10'd57, 16'h8802, 1'b0, 1'b0);
        px(1'b1, 10'd112, 10'd58, 16'h8803, 1'b0, 1'b0);
        chk("coll_before_reset", {31'd0, collision}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; pix_valid = 1'b0; frame_start = 1'b0;
        aq.delete();
        pq.delete();
        @(negedge clk);
        chk("midrst_pix_out", {16'd0, pix_out}, 32'd0);
        chk("midrst_valid", {31'd0, pix_out_valid}, 32'd0);
        chk("midrst_bird_px", {31'd0, bird_px}, 32'd0);
        chk("midrst_collision", {31'd0, collision}, 32'd0);
        chk("midrst_rom_addr", {19'd0, rom_addr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        idle(5);
        px(1'b1, 10'd100, 10'd228, 16'h9900, 1'b0, 1'b0);
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
